// File: rtl/common.sv
// MIPS opcode and function-field constants shared by the decode path.
package common;

  localparam logic [5:0] F6_R_TYPE = 6'h00;
  localparam logic [5:0] F6_ADDI   = 6'h08;
  localparam logic [5:0] F6_ORI    = 6'h0D;
  localparam logic [5:0] F6_LW     = 6'h23;
  localparam logic [5:0] F6_SW     = 6'h2B;
  localparam logic [5:0] F6_BEQ    = 6'h04;
  localparam logic [5:0] F6_BNE    = 6'h05;
  localparam logic [5:0] F6_LUI    = 6'h0F;
  localparam logic [5:0] F6_NOP    = 6'h00;

endpackage

// File: rtl/pipes.sv
// Inter-stage bundle from decode to execute.
package pipes;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] signimm32;
    logic [31:0] zeroimm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  alu_op;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        illegal;
  } d_e_reg_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational instruction decoder: fields, control bits, immediates.
module decode_ctrl
  import common::*;
  import pipes::*;
(
  input  logic [31:0] instr,
  output d_e_reg_t    dec
);

  logic [5:0]  op;
  logic [5:0]  func;
  logic [15:0] imm;
  logic        r_t, addi, ori, lw, sw, beq, bne, lui, known;

  assign op   = instr[31:26];
  assign func = instr[5:0];
  assign imm  = instr[15:0];

  assign r_t   = op == F6_R_TYPE;
  assign addi  = op == F6_ADDI;
  assign ori   = op == F6_ORI;
  assign lw    = op == F6_LW;
  assign sw    = op == F6_SW;
  assign beq   = op == F6_BEQ;
  assign bne   = op == F6_BNE;
  assign lui   = op == F6_LUI;
  assign known = r_t | addi | ori | lw | sw | beq | bne | lui;

  always_comb begin
    dec            = '0;
    dec.rs         = instr[25:21];
    dec.rt         = instr[20:16];
    dec.rd         = instr[15:11];
    dec.shamt      = instr[10:6];
    dec.zeroimm32  = {16'b0, imm};
    dec.signimm32  = {{16{imm[15]}}, imm};
    dec.illegal    = !known;
    dec.reg_write  = (r_t && func != F6_NOP)
                   | addi | ori | lw | lui;
    dec.mem_to_reg = lw;
    dec.mem_write  = sw;
    dec.alu_src    = addi | ori | lw | sw | lui;
    dec.reg_dst    = r_t;
    dec.branch     = beq | bne;
    // Illegal opcodes carry no ALU operation either.
    unique case (1'b1)
      !known:       dec.alu_op = '0;
      r_t:          dec.alu_op = func;
      known && !r_t: dec.alu_op = op;
      default:      dec.alu_op = '0;
    endcase
  end

endmodule

// File: rtl/decode_queue_stage.sv
// Queued decode stage with valid/ready on both sides and flush.
// Load-use interlock enabled by defining DECODE_LOAD_USE_EN.
module decode_queue_stage
  import pipes::*;
#(
  parameter int IQ_DEPTH = 4,
  localparam int CNT_W = $clog2(IQ_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc_plus_4,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic [4:0]       rs_addr,
  output logic [4:0]       rt_addr,
  input  logic [31:0]      rd1,
  input  logic [31:0]      rd2,
  output logic             out_valid,
  input  logic             out_ready,
  output d_e_reg_t         d_e,
  output logic [CNT_W-1:0] iq_count
);

  localparam int PTR_W = $clog2(IQ_DEPTH);

  logic [31:0]      mem_pc    [IQ_DEPTH];
  logic [31:0]      mem_instr [IQ_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      head_instr;
  logic             push, issue, head_valid, hazard;
  d_e_reg_t         dec, nxt;

  assign head_instr = mem_instr[rd_ptr];
  assign rs_addr    = head_instr[25:21];
  assign rt_addr    = head_instr[20:16];
  assign head_valid = count != '0;
  assign in_ready   = (count < CNT_W'(IQ_DEPTH)) && !flush;
  assign iq_count   = count;
  assign push       = in_valid && in_ready;

  decode_ctrl u_dec (
    .instr (head_instr),
    .dec   (dec)
  );

`ifdef DECODE_LOAD_USE_EN
  logic head_uses_rt;
  // R-type, store and branch all read rt as a source.
  assign head_uses_rt = dec.reg_dst | dec.mem_write | dec.branch;
  assign hazard = out_valid && d_e.mem_to_reg && d_e.reg_write
               && d_e.rt != '0
               && (d_e.rt == dec.rs
                   || (d_e.rt == dec.rt && head_uses_rt));
`else
  assign hazard = 1'b0;
`endif

  assign issue = head_valid && (!out_valid || out_ready)
              && !hazard && !flush;

  always_comb begin
    nxt           = dec;
    nxt.pc_plus_4 = mem_pc[rd_ptr];
    nxt.rd1       = rd1;
    nxt.rd2       = rd2;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= in_pc_plus_4;
      mem_instr[wr_ptr] <= in_instr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      d_e       <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (issue) begin
        rd_ptr    <= rd_ptr + 1'b1;
        d_e       <= nxt;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (push && !issue)      count <= count + 1'b1;
      else if (!push && issue) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Scoreboard bench for decode_queue_stage with a behavioural decode model.
module tb_decode_queue_stage;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc_plus_4 = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rd1, rd2;
  logic        out_valid;
  logic        out_ready = 1'b0;
  d_e_reg_t    d_e;
  logic [2:0]  iq_count;

  int          total = 0;
  int          passed = 0;
  int          acc = 0;
  logic [31:0] pc = 32'h0000_1004;
  d_e_reg_t    expq[$];

`ifdef DECODE_LOAD_USE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif

  decode_queue_stage #(.IQ_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc_plus_4 (in_pc_plus_4),
    .in_instr     (in_instr),
    .flush        (flush),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rd1          (rd1),
    .rd2          (rd2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .d_e          (d_e),
    .iq_count     (iq_count)
  );

  always #5 clk = ~clk;

  // Register file stand-in: data is a fixed tag plus the address.
  assign rd1 = 32'hA500_0000 | {27'b0, rs_addr};
  assign rd2 = 32'h5A00_0000 | {27'b0, rt_addr};

  function automatic d_e_reg_t model(input logic [31:0] p,
                                     input logic [31:0] ins);
    d_e_reg_t e;
    logic [5:0] op;
    logic [5:0] f;
    op = ins[31:26];
    f  = ins[5:0];
    e = '0;
    e.pc_plus_4 = p;
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.rd = ins[15:11];
    e.shamt = ins[10:6];
    e.rd1 = 32'hA500_0000 + 32'(ins[25:21]);
    e.rd2 = 32'h5A00_0000 + 32'(ins[20:16]);
    e.zeroimm32 = 32'(ins[15:0]);
    e.signimm32 = 32'(signed'(ins[15:0]));
    case (op)
      6'h00: begin
        e.reg_dst = 1'b1;
        e.reg_write = f != 6'h00;
        e.alu_op = f;
      end
      6'h08, 6'h0D, 6'h0F: begin
        e.reg_write = 1'b1;
        e.alu_src = 1'b1;
        e.alu_op = op;
      end
      6'h23: begin
        e.reg_write = 1'b1;
        e.mem_to_reg = 1'b1;
        e.alu_src = 1'b1;
        e.alu_op = op;
      end
      6'h2B: begin
        e.mem_write = 1'b1;
        e.alu_src = 1'b1;
        e.alu_op = op;
      end
      6'h04, 6'h05: begin
        e.branch = 1'b1;
        e.alu_op = op;
      end
      default: e.illegal = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0]  s, t, d;
    logic [15:0] imm;
    s = 5'($urandom_range(3));
    t = 5'($urandom_range(3));
    d = 5'($urandom_range(3));
    imm = 16'($urandom);
    case ($urandom_range(11))
      0:  return {6'h00, s, t, d, 5'd0, 6'h20};
      1:  return {6'h00, s, t, d, 5'd2, 6'h25};
      2:  return {6'h08, s, t, imm};
      3:  return {6'h0D, s, t, imm};
      4, 5: return {6'h23, s, t, imm};
      6:  return {6'h2B, s, t, imm};
      7:  return {6'h04, s, t, imm};
      8:  return {6'h05, s, t, imm};
      9:  return {6'h0F, 5'd0, t, imm};
      10: return 32'h0000_0000;
      default: return {6'h3F, s, t, imm};
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_de(input string name, input d_e_reg_t act,
                          input d_e_reg_t exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle's inputs, then record what the coming edge accepts.
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid = v;
    in_instr = ins;
    in_pc_plus_4 = pc;
    out_ready = ordy;
    flush = fl;
    @(negedge clk);
    if (fl) expq.delete();
    if (in_valid && in_ready) begin
      expq.push_back(model(pc, ins));
      pc += 32'd4;
      acc++;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        total++;
        $display("FAIL unexpected_out: got %h expected none", d_e);
      end else begin
        check_de("scoreboard", d_e, expq.pop_front());
      end
    end
  end

  logic [31:0] fill [7];

  initial begin
    fill[0] = 32'hFC00_0000;
    fill[1] = 32'h0000_0000;
    fill[2] = 32'h3421_ABCD;
    fill[3] = 32'hAC22_0004;
    fill[4] = 32'h1022_0003;
    fill[5] = 32'h3C01_FFFF;
    fill[6] = 32'h1422_8000;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_iq_count", 64'(iq_count), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check_de("reset_d_e", d_e, '0);

    step(1'b1, 32'h2001_FFFF, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("latency_no_bypass", 64'(out_valid), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("latency_valid", 64'(out_valid), 64'd1);
    check("addi_signimm", 64'(d_e.signimm32), 64'hFFFF_FFFF);
    check("addi_zeroimm", 64'(d_e.zeroimm32), 64'h0000_FFFF);
    check("addi_ctrl", 64'({d_e.reg_write, d_e.alu_src}), 64'd3);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    acc = 0;
    for (int i = 0; i < 7; i++) step(1'b1, fill[i], 1'b0, 1'b0);
    check("full_iq_count", 64'(iq_count), 64'd4);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_accepted", 64'(acc), 64'd5);
    check("stall_hold_valid", 64'(out_valid), 64'd1);
    check_de("stall_hold_head", d_e, model(pc - 32'd20, fill[0]));
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_empty", 64'(expq.size()), 64'd0);

    step(1'b1, 32'h8C02_0000, 1'b1, 1'b0);
    step(1'b1, 32'h0042_1820, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("lu_load_out", 64'(out_valid), 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("lu_second", 64'(out_valid), LU ? 64'd0 : 64'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("lu_third", 64'(out_valid), LU ? 64'd1 : 64'd0);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("lu_empty", 64'(expq.size()), 64'd0);

    for (int i = 0; i < 4; i++) step(1'b1, fill[i + 2], 1'b0, 1'b0);
    step(1'b1, 32'h2003_0007, 1'b0, 1'b1);
    check("pre_flush_count", 64'(iq_count), 64'd3);
    check("pre_flush_valid", 64'(out_valid), 64'd1);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_iq_count", 64'(iq_count), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("flush_dropped", 64'({out_valid, iq_count}), 64'd0);

    step(1'b1, 32'h3404_1234, 1'b0, 1'b0);
    step(1'b1, 32'h3405_4321, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_iq_count", 64'(iq_count), 64'd0);
    expq.delete();
    #1 reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      logic v, r, f;
      v = $urandom_range(3) != 0;
      r = $urandom_range(3) != 0;
      f = $urandom_range(49) == 0;
      if (f) r = 1'b0;
      step(v, gen(), r, f);
    end
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b0);
    check("random_drained", 64'(expq.size()), 64'd0);
    check("random_idle", 64'({out_valid, iq_count}), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
